multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 173 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS-style datapath (fetch/decode/execute/memory/writeback).
// Optional macro MC_BNE_EN adds bne (opcode 000101) as a branch with an inverted zero qualifier.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       IorD,
  output logic       IRwrite,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       alu_srcA,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_srcB,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [2:0] alu_ctrl,
  output logic       zero_in_PC,
  output logic       inst_done
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EXE,
    S_R_WB, S_I_EXE, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;

  typedef struct packed {
    logic       iord, ir_write, pc_write, pc_write_cond;
    logic       alu_src_a, reg_write, mem_read, mem_write;
    logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg;
    logic [2:0] alu_ctrl;
    logic       branch, branch_ne, inst_done;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, FN_JR = 6'b001000;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR = 3'b001, ALU_SLT = 3'b111;

  state_t     state_q, state_d, decode_tgt, ctl_state;
  ctl_t       ctl_q, ctl_d;
  logic       is_bne;
  logic [2:0] r_alu;

`ifdef MC_BNE_EN
  assign is_bne = (opcode == 6'b000101);
`else
  assign is_bne = 1'b0;
`endif

  always_comb begin
    decode_tgt = S_FETCH;
    case (opcode)
      OP_LW, OP_SW:     decode_tgt = S_MEM_ADR;
      OP_RTYPE:         decode_tgt = (func == FN_JR) ? S_JR : S_R_EXE;
      OP_ADDI, OP_SLTI: decode_tgt = S_I_EXE;
      OP_BEQ:           decode_tgt = S_BRANCH;
      OP_J:             decode_tgt = S_JUMP;
      OP_JAL:           decode_tgt = S_JAL;
      default:          decode_tgt = S_FETCH;
    endcase
    if (is_bne) decode_tgt = S_BRANCH;
  end

  always_comb begin
    case (func)
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = decode_tgt;
      S_MEM_ADR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = S_MEM_WB;
      S_R_EXE:   state_d = S_R_WB;
      S_I_EXE:   state_d = S_I_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the state being entered so they come straight off flops.
  assign ctl_state = rst ? S_FETCH : state_d;

  always_comb begin
    ctl_d = '0;
    case (ctl_state)
      S_FETCH: begin
        ctl_d.mem_read = 1'b1; ctl_d.ir_write = 1'b1; ctl_d.pc_write = 1'b1;
        ctl_d.alu_src_b = 2'b01; ctl_d.alu_ctrl = ALU_ADD;
      end
      S_DECODE: begin
        ctl_d.alu_src_b = 2'b11; ctl_d.alu_ctrl = ALU_ADD;
      end
      S_MEM_ADR: begin
        ctl_d.alu_src_a = 1'b1; ctl_d.alu_src_b = 2'b10; ctl_d.alu_ctrl = ALU_ADD;
      end
      S_MEM_RD: begin
        ctl_d.mem_read = 1'b1; ctl_d.iord = 1'b1;
      end
      S_MEM_WB: begin
        ctl_d.reg_write = 1'b1; ctl_d.mem_to_reg = 2'b01; ctl_d.inst_done = 1'b1;
      end
      S_MEM_WR: begin
        ctl_d.mem_write = 1'b1; ctl_d.iord = 1'b1; ctl_d.inst_done = 1'b1;
      end
      S_R_EXE: begin
        ctl_d.alu_src_a = 1'b1; ctl_d.alu_ctrl = r_alu;
      end
      S_R_WB: begin
        ctl_d.reg_write = 1'b1; ctl_d.reg_dst = 2'b01; ctl_d.inst_done = 1'b1;
      end
      S_I_EXE: begin
        ctl_d.alu_src_a = 1'b1; ctl_d.alu_src_b = 2'b10;
        ctl_d.alu_ctrl = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB: begin
        ctl_d.reg_write = 1'b1; ctl_d.inst_done = 1'b1;
      end
      S_BRANCH: begin
        ctl_d.alu_src_a = 1'b1; ctl_d.alu_ctrl = ALU_SUB; ctl_d.pc_write_cond = 1'b1;
        ctl_d.pc_src = 2'b10; ctl_d.branch = 1'b1; ctl_d.branch_ne = is_bne;
        ctl_d.inst_done = 1'b1;
      end
      S_JUMP: begin
        ctl_d.pc_write = 1'b1; ctl_d.pc_src = 2'b01; ctl_d.inst_done = 1'b1;
      end
      S_JAL: begin
        ctl_d.pc_write = 1'b1; ctl_d.pc_src = 2'b01; ctl_d.reg_write = 1'b1;
        ctl_d.reg_dst = 2'b10; ctl_d.mem_to_reg = 2'b10; ctl_d.inst_done = 1'b1;
      end
      S_JR: begin
        ctl_d.pc_write = 1'b1; ctl_d.pc_src = 2'b11; ctl_d.inst_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
    ctl_q <= ctl_d;
  end

  assign IorD          = ctl_q.iord;
  assign alu_srcA      = ctl_q.alu_src_a;
  assign mem_read      = ctl_q.mem_read;
  assign alu_srcB      = ctl_q.alu_src_b;
  assign pc_src        = ctl_q.pc_src;
  assign reg_dst       = ctl_q.reg_dst;
  assign mem_to_reg    = ctl_q.mem_to_reg;
  assign alu_ctrl      = ctl_q.alu_ctrl;
  assign IRwrite       = ctl_q.ir_write & ~rst;
  assign pc_write      = ctl_q.pc_write & ~rst;
  assign pc_write_cond = ctl_q.pc_write_cond & ~rst;
  assign reg_write     = ctl_q.reg_write & ~rst;
  assign mem_write     = ctl_q.mem_write & ~rst;
  // IR only becomes valid in DECODE, so an illegal opcode's done pulse is decoded live there.
  assign inst_done     = (ctl_q.inst_done | ((state_q == S_DECODE) && (decode_tgt == S_FETCH))) & ~rst;
  assign zero_in_PC    = ctl_q.branch & (zero ^ ctl_q.branch_ne);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expected output
// sequences are queued when the instruction is presented and compared cycle by cycle.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic       zero;
  logic       IorD, IRwrite, pc_write, pc_write_cond, alu_srcA, reg_write, mem_read, mem_write;
  logic [1:0] alu_srcB, pc_src, reg_dst, mem_to_reg;
  logic [2:0] alu_ctrl;
  logic       zero_in_PC, inst_done;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .IorD(IorD), .IRwrite(IRwrite), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .alu_srcA(alu_srcA), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_srcB(alu_srcB), .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_ctrl(alu_ctrl), .zero_in_PC(zero_in_PC), .inst_done(inst_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord, irw, pcw, pcwc, srca, regw, memr, memw;
    logic [1:0] srcb, pcsrc, regdst, m2r;
    logic [2:0] aluc;
    logic       zpc, done;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  exp;
  } sb_t;

  sb_t  sb_q[$];
  ctl_t obs;
  int   n_checks = 0;
  int   n_errors = 0;

  assign obs = {IorD, IRwrite, pc_write, pc_write_cond, alu_srcA, reg_write, mem_read, mem_write,
                alu_srcB, pc_src, reg_dst, mem_to_reg, alu_ctrl, zero_in_PC, inst_done};

  task automatic check(input string tag, input ctl_t got, input ctl_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctl_t c_fetch();
    ctl_t c = '0;
    c.memr = 1'b1; c.irw = 1'b1; c.pcw = 1'b1; c.srcb = 2'b01; c.aluc = 3'b010;
    return c;
  endfunction

  function automatic ctl_t c_decode(input logic illegal);
    ctl_t c = '0;
    c.srcb = 2'b11; c.aluc = 3'b010; c.done = illegal;
    return c;
  endfunction

  function automatic ctl_t c_exe(input logic [1:0] srcb, input logic [2:0] aluc);
    ctl_t c = '0;
    c.srca = 1'b1; c.srcb = srcb; c.aluc = aluc;
    return c;
  endfunction

  function automatic ctl_t c_wb(input logic [1:0] regdst, input logic [1:0] m2r);
    ctl_t c = '0;
    c.regw = 1'b1; c.regdst = regdst; c.m2r = m2r; c.done = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_mem(input logic wr);
    ctl_t c = '0;
    c.iord = 1'b1; c.memr = ~wr; c.memw = wr; c.done = wr;
    return c;
  endfunction

  function automatic ctl_t c_branch(input logic zpc);
    ctl_t c = '0;
    c.srca = 1'b1; c.aluc = 3'b110; c.pcwc = 1'b1; c.pcsrc = 2'b10; c.zpc = zpc; c.done = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_jump(input logic [1:0] pcsrc, input logic link);
    ctl_t c = '0;
    c.pcw = 1'b1; c.pcsrc = pcsrc; c.done = 1'b1;
    if (link) begin
      c.regw = 1'b1; c.regdst = 2'b10; c.m2r = 2'b10;
    end
    return c;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic push(input string tag, input ctl_t exp);
    sb_t e;
    e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; each entry is compared one step later, then the clock advances.
  task automatic drain();
    sb_t e;
    int  guard = 0;
    while (sb_q.size() > 0) begin
      guard++;
      if (guard > 16) begin
        n_checks++; n_errors++;
        $display("FAIL drain_bound: %0d entries left, required 0", sb_q.size());
        sb_q.delete();
      end else begin
        e = sb_q.pop_front();
        #1;
        check(e.tag, obs, e.exp);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_inst(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic z);
    opcode = op; func = fn; zero = z;
    push({tag, "/fetch"}, c_fetch());
    case (op)
      6'b100011: begin
        push({tag, "/decode"}, c_decode(1'b0));
        push({tag, "/mem_adr"}, c_exe(2'b10, 3'b010));
        push({tag, "/mem_rd"}, c_mem(1'b0));
        push({tag, "/mem_wb"}, c_wb(2'b00, 2'b01));
      end
      6'b101011: begin
        push({tag, "/decode"}, c_decode(1'b0));
        push({tag, "/mem_adr"}, c_exe(2'b10, 3'b010));
        push({tag, "/mem_wr"}, c_mem(1'b1));
      end
      6'b000000: begin
        push({tag, "/decode"}, c_decode(1'b0));
        if (fn == 6'b001000) push({tag, "/jr"}, c_jump(2'b11, 1'b0));
        else begin
          push({tag, "/r_exe"}, c_exe(2'b00, alu_of(fn)));
          push({tag, "/r_wb"}, c_wb(2'b01, 2'b00));
        end
      end
      6'b001000, 6'b001010: begin
        push({tag, "/decode"}, c_decode(1'b0));
        push({tag, "/i_exe"}, c_exe(2'b10, (op == 6'b001010) ? 3'b111 : 3'b010));
        push({tag, "/i_wb"}, c_wb(2'b00, 2'b00));
      end
      6'b000100: begin
        push({tag, "/decode"}, c_decode(1'b0));
        push({tag, "/branch"}, c_branch(z));
      end
`ifdef MC_BNE_EN
      6'b000101: begin
        push({tag, "/decode"}, c_decode(1'b0));
        push({tag, "/branch"}, c_branch(~z));
      end
`endif
      6'b000010: begin
        push({tag, "/decode"}, c_decode(1'b0));
        push({tag, "/jump"}, c_jump(2'b01, 1'b0));
      end
      6'b000011: begin
        push({tag, "/decode"}, c_decode(1'b0));
        push({tag, "/jal"}, c_jump(2'b01, 1'b1));
      end
      default: push({tag, "/decode_illegal"}, c_decode(1'b1));
    endcase
    drain();
  endtask

  initial begin
    ctl_t rst_exp;
    rst = 1'b1; opcode = '0; func = '0; zero = 1'b0;
    rst_exp = c_fetch();
    rst_exp.irw = 1'b0; rst_exp.pcw = 1'b0;
    @(posedge clk); #1;
    check("reset_hold0", obs, rst_exp);
    @(posedge clk); #1;
    check("reset_hold1", obs, rst_exp);
    rst = 1'b0;

    run_inst("lw",       6'b100011, 6'b000000, 1'b1);
    run_inst("sw",       6'b101011, 6'b000000, 1'b1);
    run_inst("r_add",    6'b000000, 6'b100000, 1'b1);
    run_inst("r_sub",    6'b000000, 6'b100010, 1'b1);
    run_inst("r_and",    6'b000000, 6'b100100, 1'b0);
    run_inst("r_or",     6'b000000, 6'b100101, 1'b1);
    run_inst("r_slt",    6'b000000, 6'b101010, 1'b0);
    run_inst("r_badfn",  6'b000000, 6'b000111, 1'b1);
    run_inst("jr",       6'b000000, 6'b001000, 1'b1);
    run_inst("addi",     6'b001000, 6'b100010, 1'b1);
    run_inst("slti",     6'b001010, 6'b000000, 1'b1);
    run_inst("beq_z1",   6'b000100, 6'b000000, 1'b1);
    run_inst("beq_z0",   6'b000100, 6'b000000, 1'b0);
    run_inst("j",        6'b000010, 6'b000000, 1'b1);
    run_inst("jal",      6'b000011, 6'b000000, 1'b1);
    run_inst("bne_z1",   6'b000101, 6'b000000, 1'b1);
    run_inst("bne_z0",   6'b000101, 6'b000000, 1'b0);
    run_inst("ill_3f",   6'b111111, 6'b000000, 1'b1);
    run_inst("ill_10",   6'b010000, 6'b100000, 1'b0);

    // Reset landing in MEM_RD of a load: no writeback, straight back to FETCH.
    opcode = 6'b100011; func = '0; zero = 1'b0;
    push("lw_rst/fetch", c_fetch());
    push("lw_rst/decode", c_decode(1'b0));
    push("lw_rst/mem_adr", c_exe(2'b10, 3'b010));
    drain();
    rst = 1'b1;
    #1;
    check("lw_rst/mem_rd_in_reset", obs, c_mem(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    run_inst("after_rst_lw", 6'b100011, 6'b000000, 1'b1);
    run_inst("final_j", 6'b000010, 6'b000000, 1'b0);
    #1;
    check("final_fetch", obs, c_fetch());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
